mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: holds one op in M, talks to data memory,
// formats loads and hands the result to the W registers.
module mem_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_E,
  input  logic             regWrite_E,
  input  logic             memWrite_E,
  input  logic             memRead_E,
  input  logic [1:0]       resultSrc_E,
  input  logic [2:0]       funct3_E,
  input  logic [4:0]       Rd_E,
  input  logic [WIDTH-1:0] ALUResult_E,
  input  logic [WIDTH-1:0] writeData_E,
  input  logic [WIDTH-1:0] PCPlus4_E,
  output logic             stall_M,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             valid_W,
  output logic             regWrite_W,
  output logic             misalign_W,
  output logic [1:0]       resultSrc_W,
  output logic [4:0]       Rd_W,
  output logic [WIDTH-1:0] ALUResult_W,
  output logic [WIDTH-1:0] readData_W,
  output logic [WIDTH-1:0] PCPlus4_W
);

  typedef enum logic [1:0] {
    EMPTY, PASS, WAIT
  } state_t;

  state_t state_q, state_d;

  logic             m_rw_q, m_mw_q, m_mr_q;
  logic [1:0]       m_rs_q;
  logic [2:0]       m_f3_q;
  logic [4:0]       m_rd_q;
  logic [WIDTH-1:0] m_alu_q, m_wd_q, m_pc4_q;

  logic [1:0]       off;
  logic             m_mem, m_bad, m_load;
  logic             e_mem, e_bad, w_load;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [WIDTH-1:0] rd_fmt;

  // Size/alignment legality; illegal funct3 counts as bad
  function automatic logic bad_acc(
    input logic [2:0] f3,
    input logic [1:0] o
  );
    logic b;
    case (f3)
      3'b000, 3'b100: b = 1'b0;
      3'b001, 3'b101: b = o[0];
      3'b010:         b = (o != 2'b00);
      default:        b = 1'b1;
    endcase
    return b;
  endfunction

  assign off    = m_alu_q[1:0];
  assign m_mem  = m_mr_q | m_mw_q;
  assign m_bad  = m_mem & bad_acc(m_f3_q, off);
  assign m_load = m_mr_q & ~m_mw_q;
  assign e_mem  = memRead_E | memWrite_E;
  assign e_bad  = e_mem &
                  bad_acc(funct3_E, ALUResult_E[1:0]);

  assign stall_M  = (state_q == WAIT) & ~mem_ack;
  assign w_load   = (state_q == PASS) |
                    ((state_q == WAIT) & mem_ack);
  assign mem_req  = (state_q == WAIT);
  assign mem_we   = mem_req & m_mw_q;
  assign mem_addr = {m_alu_q[WIDTH-1:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Next state: classify the incoming op when not stalled
  always_comb begin
    state_d = state_q;
    if (!stall_M) begin
      if (!valid_E)            state_d = EMPTY;
      else if (e_mem && !e_bad) state_d = WAIT;
      else                     state_d = PASS;
    end
  end

  // M register: load on accept, clear on a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rw_q  <= 1'b0;
      m_mw_q  <= 1'b0;
      m_mr_q  <= 1'b0;
      m_rs_q  <= '0;
      m_f3_q  <= '0;
      m_rd_q  <= '0;
      m_alu_q <= '0;
      m_wd_q  <= '0;
      m_pc4_q <= '0;
    end else if (!stall_M) begin
      m_rw_q  <= valid_E & regWrite_E &
                 ~(memRead_E & memWrite_E);
      m_mw_q  <= valid_E & memWrite_E;
      m_mr_q  <= valid_E & memRead_E;
      m_rs_q  <= valid_E ? resultSrc_E : '0;
      m_f3_q  <= valid_E ? funct3_E    : '0;
      m_rd_q  <= valid_E ? Rd_E        : '0;
      m_alu_q <= valid_E ? ALUResult_E : '0;
      m_wd_q  <= valid_E ? writeData_E : '0;
      m_pc4_q <= valid_E ? PCPlus4_E   : '0;
    end
  end

  // Store lanes and replicated write data
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = m_wd_q;
    case (m_f3_q[1:0])
      2'b00:   mem_wdata = {4{m_wd_q[7:0]}};
      2'b01:   mem_wdata = {2{m_wd_q[15:0]}};
      default: mem_wdata = m_wd_q;
    endcase
    if (mem_req) begin
      if (!m_mw_q) mem_be = 4'b1111;
      else begin
        case (m_f3_q[1:0])
          2'b00:   mem_be = 4'b0001 << off;
          2'b01:   mem_be = 4'b0011 << off;
          default: mem_be = 4'b1111;
        endcase
      end
    end
  end

  // Load lane select and sign/zero extension
  always_comb begin
    lane_b = mem_rdata[8*off +: 8];
    lane_h = off[1] ? mem_rdata[31:16]
                    : mem_rdata[15:0];
    rd_fmt = '0;
    case (m_f3_q)
      3'b000:  rd_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  rd_fmt = {{16{lane_h[15]}}, lane_h};
      3'b010:  rd_fmt = mem_rdata;
      3'b100:  rd_fmt = {24'd0, lane_b};
      3'b101:  rd_fmt = {16'd0, lane_h};
      default: rd_fmt = '0;
    endcase
  end

  // W registers: pulse valid, hold payload otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_W     <= 1'b0;
      regWrite_W  <= 1'b0;
      misalign_W  <= 1'b0;
      resultSrc_W <= '0;
      Rd_W        <= '0;
      ALUResult_W <= '0;
      readData_W  <= '0;
      PCPlus4_W   <= '0;
    end else begin
      valid_W <= w_load;
      if (w_load) begin
        regWrite_W  <= m_rw_q & ~m_bad;
        misalign_W  <= m_bad;
        resultSrc_W <= m_rs_q;
        Rd_W        <= m_rd_q;
        ALUResult_W <= m_alu_q;
        readData_W  <= (state_q == WAIT && m_load)
                       ? rd_fmt : '0;
        PCPlus4_W   <= m_pc4_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass, loads,
// stores, misalign, back-to-back and reset in WAIT.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E, regWrite_E, memWrite_E, memRead_E;
  logic [1:0]  resultSrc_E;
  logic [2:0]  funct3_E;
  logic [4:0]  Rd_E;
  logic [31:0] ALUResult_E, writeData_E, PCPlus4_E;
  logic        stall_M, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        valid_W, regWrite_W, misalign_W;
  logic [1:0]  resultSrc_W;
  logic [4:0]  Rd_W;
  logic [31:0] ALUResult_W, readData_W, PCPlus4_W;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .valid_E(valid_E), .regWrite_E(regWrite_E),
    .memWrite_E(memWrite_E), .memRead_E(memRead_E),
    .resultSrc_E(resultSrc_E), .funct3_E(funct3_E),
    .Rd_E(Rd_E), .ALUResult_E(ALUResult_E),
    .writeData_E(writeData_E), .PCPlus4_E(PCPlus4_E),
    .stall_M(stall_M), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_W(valid_W), .regWrite_W(regWrite_W),
    .misalign_W(misalign_W), .resultSrc_W(resultSrc_W),
    .Rd_W(Rd_W), .ALUResult_W(ALUResult_W),
    .readData_W(readData_W), .PCPlus4_W(PCPlus4_W)
  );

  task automatic idle();
    valid_E = 0; regWrite_E = 0;
    memWrite_E = 0; memRead_E = 0;
    resultSrc_E = 0; funct3_E = 0; Rd_E = 0;
    ALUResult_E = 0; writeData_E = 0; PCPlus4_E = 0;
  endtask

  task automatic op(input logic rw, mw, mr,
                    input logic [2:0] f3,
                    input logic [4:0] rd,
                    input logic [31:0] alu, wd);
    valid_E = 1; regWrite_E = rw;
    memWrite_E = mw; memRead_E = mr;
    resultSrc_E = 2'b01; funct3_E = f3; Rd_E = rd;
    ALUResult_E = alu; writeData_E = wd;
    PCPlus4_E = alu + 32'd4;
  endtask

  task automatic test_reset();
    rst = 0; mem_ack = 0; mem_rdata = 0; idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_W, mem_req, stall_M, mem_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000",
               {valid_W, mem_req, stall_M, mem_we});
    end
    checks++;
    if (mem_be !== 4'b0 || Rd_W !== 5'd0 ||
        ALUResult_W !== 32'd0 || regWrite_W !== 1'b0) begin
      errors++;
      $display("FAIL reset_w be=%b rd=%0d alu=%h rw=%b want 0",
               mem_be, Rd_W, ALUResult_W, regWrite_W);
    end
    rst = 1;
  endtask

  task automatic test_alu();
    op(1, 0, 0, 3'b000, 5'd5, 32'h1234, 32'h0);
    @(negedge clk); idle();
    checks++;
    if (valid_W !== 0 || stall_M !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL alu_e1 vW=%b st=%b req=%b want 000",
               valid_W, stall_M, mem_req);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 1 || Rd_W !== 5 ||
        ALUResult_W !== 32'h1234 || regWrite_W !== 1 ||
        misalign_W !== 0 || stall_M !== 0) begin
      errors++;
      $display("FAIL alu_w vW=%b rd=%0d alu=%h rw=%b mis=%b st=%b want 1 5 1234 1 0 0",
               valid_W, Rd_W, ALUResult_W, regWrite_W,
               misalign_W, stall_M);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 0 || Rd_W !== 5 ||
        PCPlus4_W !== 32'h1238) begin
      errors++;
      $display("FAIL alu_hold vW=%b rd=%0d pc4=%h want 0 5 1238",
               valid_W, Rd_W, PCPlus4_W);
    end
  endtask

  task automatic test_lb_wait();
    int nst = 0;
    op(1, 0, 1, 3'b000, 5'd7, 32'h103, 32'h0);
    @(negedge clk); idle();
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h100 ||
        mem_be !== 4'b1111 || mem_we !== 0) begin
      errors++;
      $display("FAIL lb_req req=%b addr=%h be=%b we=%b want 1 100 1111 0",
               mem_req, mem_addr, mem_be, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      if (stall_M === 1'b1 && mem_addr === 32'h100) nst++;
      @(negedge clk);
    end
    checks++;
    if (nst !== 3) begin
      errors++;
      $display("FAIL lb_stall got %0d cycles want 3", nst);
    end
    mem_ack = 1; mem_rdata = 32'h80FF_FFFF;
    #1;
    checks++;
    if (stall_M !== 0 || valid_W !== 0) begin
      errors++;
      $display("FAIL lb_ack st=%b vW=%b want 0 0",
               stall_M, valid_W);
    end
    @(negedge clk); mem_ack = 0; mem_rdata = 0;
    checks++;
    if (valid_W !== 1 || readData_W !== 32'hFFFF_FF80 ||
        Rd_W !== 7 || regWrite_W !== 1 ||
        mem_req !== 0) begin
      errors++;
      $display("FAIL lb_w vW=%b rdat=%h rd=%0d rw=%b req=%b want 1 ffffff80 7 1 0",
               valid_W, readData_W, Rd_W, regWrite_W, mem_req);
    end
  endtask

  task automatic test_lhu();
    op(1, 0, 1, 3'b101, 5'd8, 32'h106, 32'h0);
    @(negedge clk); idle();
    mem_ack = 1; mem_rdata = 32'h8001_2345;
    @(negedge clk); mem_ack = 0;
    checks++;
    if (valid_W !== 1 || readData_W !== 32'h0000_8001) begin
      errors++;
      $display("FAIL lhu vW=%b rdat=%h want 1 00008001",
               valid_W, readData_W);
    end
  endtask

  task automatic test_sh();
    op(0, 1, 0, 3'b001, 5'd0, 32'h202, 32'h0000_ABCD);
    @(negedge clk); idle();
    checks++;
    if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD ||
        mem_we !== 1 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL sh_req be=%b wd=%h we=%b addr=%h want 1100 abcdabcd 1 200",
               mem_be, mem_wdata, mem_we, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_ack = 0;
    checks++;
    if (valid_W !== 1 || regWrite_W !== 0 ||
        readData_W !== 0 || misalign_W !== 0) begin
      errors++;
      $display("FAIL sh_w vW=%b rw=%b rdat=%h mis=%b want 1 0 0 0",
               valid_W, regWrite_W, readData_W, misalign_W);
    end
  endtask

  task automatic test_sb();
    op(0, 1, 0, 3'b000, 5'd0, 32'h301, 32'h1234_5678);
    @(negedge clk); idle();
    checks++;
    if (mem_be !== 4'b0010 || mem_wdata !== 32'h7878_7878) begin
      errors++;
      $display("FAIL sb_req be=%b wd=%h want 0010 78787878",
               mem_be, mem_wdata);
    end
    mem_ack = 1;
    @(negedge clk); mem_ack = 0;
  endtask

  task automatic test_misalign();
    op(1, 0, 1, 3'b010, 5'd4, 32'h001, 32'h0);
    @(negedge clk); idle();
    mem_ack = 1;
    checks++;
    if (mem_req !== 0 || stall_M !== 0 || valid_W !== 0) begin
      errors++;
      $display("FAIL lw_mis_e1 req=%b st=%b vW=%b want 0 0 0",
               mem_req, stall_M, valid_W);
    end
    @(negedge clk); mem_ack = 0;
    checks++;
    if (valid_W !== 1 || misalign_W !== 1 ||
        regWrite_W !== 0 || Rd_W !== 4) begin
      errors++;
      $display("FAIL lw_mis_w vW=%b mis=%b rw=%b rd=%0d want 1 1 0 4",
               valid_W, misalign_W, regWrite_W, Rd_W);
    end
    op(1, 0, 1, 3'b011, 5'd6, 32'h040, 32'h0);
    @(negedge clk); idle();
    checks++;
    if (mem_req !== 0) begin
      errors++;
      $display("FAIL ill_req req=%b want 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 1 || misalign_W !== 1 ||
        regWrite_W !== 0) begin
      errors++;
      $display("FAIL ill_w vW=%b mis=%b rw=%b want 1 1 0",
               valid_W, misalign_W, regWrite_W);
    end
  endtask

  task automatic test_both();
    op(1, 1, 1, 3'b010, 5'd12, 32'h400, 32'h5555_AAAA);
    @(negedge clk); idle();
    checks++;
    if (mem_we !== 1 || mem_be !== 4'b1111 ||
        mem_wdata !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL both_req we=%b be=%b wd=%h want 1 1111 5555aaaa",
               mem_we, mem_be, mem_wdata);
    end
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    @(negedge clk); mem_ack = 0;
    checks++;
    if (valid_W !== 1 || regWrite_W !== 0 ||
        readData_W !== 0) begin
      errors++;
      $display("FAIL both_w vW=%b rw=%b rdat=%h want 1 0 0",
               valid_W, regWrite_W, readData_W);
    end
  endtask

  task automatic test_back_to_back();
    op(0, 1, 0, 3'b010, 5'd3, 32'h300, 32'hDEAD_BEEF);
    @(negedge clk);
    op(1, 0, 0, 3'b000, 5'd9, 32'h55, 32'h0);
    mem_ack = 1;
    #1;
    checks++;
    if (stall_M !== 0 || mem_req !== 1 ||
        mem_be !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL b2b_ack st=%b req=%b be=%b wd=%h want 0 1 1111 deadbeef",
               stall_M, mem_req, mem_be, mem_wdata);
    end
    @(negedge clk); idle(); mem_ack = 0;
    checks++;
    if (valid_W !== 1 || Rd_W !== 3 || regWrite_W !== 0) begin
      errors++;
      $display("FAIL b2b_w1 vW=%b rd=%0d rw=%b want 1 3 0",
               valid_W, Rd_W, regWrite_W);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 1 || Rd_W !== 9 ||
        ALUResult_W !== 32'h55 || regWrite_W !== 1) begin
      errors++;
      $display("FAIL b2b_w2 vW=%b rd=%0d alu=%h rw=%b want 1 9 55 1",
               valid_W, Rd_W, ALUResult_W, regWrite_W);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 0) begin
      errors++;
      $display("FAIL b2b_end vW=%b want 0", valid_W);
    end
  endtask

  task automatic test_reset_wait();
    op(1, 0, 1, 3'b010, 5'd10, 32'h500, 32'h0);
    @(negedge clk); idle();
    checks++;
    if (mem_req !== 1 || stall_M !== 1) begin
      errors++;
      $display("FAIL rw_pre req=%b st=%b want 1 1",
               mem_req, stall_M);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (mem_req !== 0 || stall_M !== 0 ||
        valid_W !== 0 || mem_be !== 0) begin
      errors++;
      $display("FAIL rw_rst req=%b st=%b vW=%b be=%b want 0 0 0 0",
               mem_req, stall_M, valid_W, mem_be);
    end
    @(negedge clk);
    rst = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    op(1, 0, 0, 3'b000, 5'd11, 32'h77, 32'h0);
    @(negedge clk); idle(); mem_ack = 0;
    checks++;
    if (valid_W !== 0 || mem_req !== 0) begin
      errors++;
      $display("FAIL rw_after vW=%b req=%b want 0 0",
               valid_W, mem_req);
    end
    @(negedge clk);
    checks++;
    if (valid_W !== 1 || Rd_W !== 11 ||
        ALUResult_W !== 32'h77 || readData_W !== 0) begin
      errors++;
      $display("FAIL rw_next vW=%b rd=%0d alu=%h rdat=%h want 1 11 77 0",
               valid_W, Rd_W, ALUResult_W, readData_W);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_alu();
    test_lb_wait();
    test_lhu();
    test_sh();
    test_sb();
    test_misalign();
    test_both();
    test_back_to_back();
    test_reset_wait();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
